life_run_sequencer: RTL

- Sequences the Game-of-Life evolution datapath from the keyboard controller's command outputs (start/pause/clear/manual/file_id/evo_left_shift).
- Generates timed evolution steps, pattern-load requests and full-grid clear sweeps.
- Grants the grid RAM write path to exactly one owner at a time: loader, evolution engine, clear sweeper or manual editor.
- Sits between the keyboard controller and the grid memory/evolution engine.

---
 rtl/life_pkg.sv | 18 +
 rtl/life_run_sequencer_if.sv | 26 ++
 rtl/life_run_sequencer_evo_tick_gen.sv | 48 ++++
 rtl/life_run_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: definitions shared by the run sequencer, the keyboard
// controller and the display logic.
//   seq_state_t     - run sequencer FSM state (3-bit, shown on the display)
//   MAX_SPEED_SHIFT - largest evo_left_shift honoured; larger values clamp
package life_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_EVOLVE = 3'd4,
        ST_EDIT   = 3'd5
    } seq_state_t;

    localparam logic [3:0] MAX_SPEED_SHIFT = 4'd5;

endpackage

// File: rtl/life_run_sequencer_if.sv
// life_run_sequencer_if: grid-memory / evolution-engine handshake bundle.
//   load_req, load_file_id / load_done : pattern loader request/complete
//   evo_start / evo_done               : one-generation launch/complete
//   clr_we, clr_addr                   : clear-sweep write port (data is 0)
// master = sequencer side, slave = loader / engine / RAM side.
interface life_run_sequencer_if #(
    parameter int ADDR_W = 12
) ();
    logic              load_req;
    logic [15:0]       load_file_id;
    logic              load_done;
    logic              evo_start;
    logic              evo_done;
    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    modport master (
        output load_req, load_file_id, evo_start, clr_we, clr_addr,
        input  load_done, evo_done
    );

    modport slave (
        input  load_req, load_file_id, evo_start, clr_we, clr_addr,
        output load_done, evo_done
    );
endinterface

// File: rtl/life_run_sequencer_evo_tick_gen.sv
// evo_tick_gen: generation period counter.
//   clk_in, reset : clock, asynchronous active-high reset
//   clr           : force count to 0
//   en            : count this cycle
//   speed_shift   : period = BASE_PERIOD >> min(speed_shift, MAX_SPEED_SHIFT)
//   tick          : terminal count reached (count >= period-1 while en);
//                   the count restarts from 0 on the cycle after a tick
module evo_tick_gen
    import life_pkg::*;
#(
    parameter int BASE_PERIOD = 50000000
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    input  logic [3:0] speed_shift,
    output logic       tick
);
    localparam logic [31:0] BASE_PERIOD_W = 32'(BASE_PERIOD);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] period;
    logic [31:0] term;
    logic [3:0]  shift_c;

    always_comb begin
        shift_c = (speed_shift > MAX_SPEED_SHIFT) ? MAX_SPEED_SHIFT : speed_shift;
        period  = BASE_PERIOD_W >> shift_c;
        term    = (period == '0) ? '0 : period - 32'd1;
        // >= rather than == so a speed-up mid-count fires at once
        tick    = en && (cnt_q >= term);
        cnt_d   = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/life_run_sequencer.sv
// life_run_sequencer: turns keyboard commands into timed evolution steps,
// pattern loads and full-grid clear sweeps, and hands the grid RAM write
// path to exactly one owner (loader, engine, clear sweep, manual editor).
//   clk_in, reset      : clock, asynchronous active-high reset
//   start/pause/clear  : command levels, rising edge acts
//   manual             : level, manual edit requested
//   file_id            : selected pattern; a change forces a reload
//   evo_left_shift     : speed, period = BASE_PERIOD >> min(shift,5)
//   step               : single-generation step (only with LIFE_SINGLE_STEP_EN)
//   mem_if (master)    : load / evolve / clear-sweep handshakes
//   edit_grant         : manual editor owns the RAM write port
//   running            : high in WAIT or EVOLVE
//   generation         : generations since last load/clear
//   seq_state          : current FSM state
// Optional feature macro: LIFE_SINGLE_STEP_EN.
module life_run_sequencer
    import life_pkg::*;
#(
    parameter int P_PARAM_N   = 64,
    parameter int P_PARAM_M   = 64,
    parameter int ADDR_W      = 12,
    parameter int BASE_PERIOD = 50000000
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        start,
    input  logic        pause,
    input  logic        clear,
    input  logic        manual,
    input  logic [15:0] file_id,
    input  logic [3:0]  evo_left_shift,
`ifdef LIFE_SINGLE_STEP_EN
    input  logic        step,
`endif
    life_run_sequencer_if.master mem_if,
    output logic        edit_grant,
    output logic        running,
    output logic [31:0] generation,
    output logic [2:0]  seq_state
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(P_PARAM_N * P_PARAM_M - 1);

    seq_state_t        state_q, state_d;
    logic              start_prev_q, pause_prev_q, clear_prev_q;
    // last_file doubles as load_file_id: both capture file_id on LOAD entry
    logic [15:0]       last_file_q, last_file_d;
    logic              file_pend_q, file_pend_d;
    logic              clr_pend_q, clr_pend_d;
    logic              pause_pend_q, pause_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [31:0]       gen_q, gen_d;
    logic              evo_start_q, evo_start_d;
    logic              step_mode_q, step_mode_d;

    logic start_ev, pause_ev, clear_ev, step_ev;
    logic file_chg, clr_any, file_any;
    logic tick;

    assign start_ev = start & ~start_prev_q;
    assign pause_ev = pause & ~pause_prev_q;
    assign clear_ev = clear & ~clear_prev_q;
    assign file_chg = (file_id != last_file_q);
    // pending flag or an event arriving this very cycle
    assign clr_any  = clr_pend_q | clear_ev;
    assign file_any = file_pend_q | file_chg;

`ifdef LIFE_SINGLE_STEP_EN
    logic step_prev_q;
    assign step_ev = step & ~step_prev_q;
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step;
        end
    end
`else
    assign step_ev = 1'b0;
`endif

    evo_tick_gen #(
        .BASE_PERIOD (BASE_PERIOD)
    ) u_tick (
        .clk_in      (clk_in),
        .reset       (reset),
        .clr         (state_q != ST_WAIT),
        .en          (state_q == ST_WAIT),
        .speed_shift (evo_left_shift),
        .tick        (tick)
    );

    always_comb begin
        state_d      = state_q;
        last_file_d  = last_file_q;
        file_pend_d  = file_pend_q | file_chg;
        clr_pend_d   = clr_any;
        pause_pend_d = pause_pend_q;
        clr_addr_d   = clr_addr_q;
        gen_d        = gen_q;
        evo_start_d  = 1'b0;
        step_mode_d  = step_mode_q;

        case (state_q)
            ST_IDLE: begin
                if (clr_any) begin
                    state_d    = ST_CLEAR;
                    clr_addr_d = '0;
                end else if (file_any) begin
                    state_d     = ST_LOAD;
                    last_file_d = file_id;
                    file_pend_d = 1'b0;
                end else if (start_ev) begin
                    state_d = ST_WAIT;
                end else if (step_ev) begin
                    state_d     = ST_EVOLVE;
                    evo_start_d = 1'b1;
                    step_mode_d = 1'b1;
                end else if (manual) begin
                    state_d = ST_EDIT;
                end
            end
            ST_LOAD: begin
                if (mem_if.load_done) begin
                    state_d = ST_IDLE;
                    gen_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = ST_IDLE;
                    gen_d      = '0;
                    clr_pend_d = clear_ev;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (pause_ev || clr_any) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d     = ST_EVOLVE;
                    evo_start_d = 1'b1;
                end
            end
            ST_EVOLVE: begin
                if (pause_ev) begin
                    pause_pend_d = 1'b1;
                end
                if (mem_if.evo_done) begin
                    gen_d        = gen_q + 32'd1;
                    pause_pend_d = 1'b0;
                    step_mode_d  = 1'b0;
                    if (clr_any || pause_pend_q || pause_ev || step_mode_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_EDIT: begin
                if (clr_any) begin
                    state_d = ST_IDLE;
                end else if (start_ev) begin
                    state_d = ST_WAIT;
                end else if (step_ev && !file_any) begin
                    state_d     = ST_EVOLVE;
                    evo_start_d = 1'b1;
                    step_mode_d = 1'b1;
                end else if (!manual) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            clear_prev_q <= 1'b0;
            last_file_q  <= '0;
            file_pend_q  <= 1'b1;
            clr_pend_q   <= 1'b0;
            pause_pend_q <= 1'b0;
            clr_addr_q   <= '0;
            gen_q        <= '0;
            evo_start_q  <= 1'b0;
            step_mode_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start;
            pause_prev_q <= pause;
            clear_prev_q <= clear;
            last_file_q  <= last_file_d;
            file_pend_q  <= file_pend_d;
            clr_pend_q   <= clr_pend_d;
            pause_pend_q <= pause_pend_d;
            clr_addr_q   <= clr_addr_d;
            gen_q        <= gen_d;
            evo_start_q  <= evo_start_d;
            step_mode_q  <= step_mode_d;
        end
    end

    assign mem_if.load_req     = (state_q == ST_LOAD);
    assign mem_if.load_file_id = last_file_q;
    assign mem_if.evo_start    = evo_start_q;
    assign mem_if.clr_we       = (state_q == ST_CLEAR);
    assign mem_if.clr_addr     = clr_addr_q;
    assign edit_grant          = (state_q == ST_EDIT);
    assign running             = (state_q == ST_WAIT) || (state_q == ST_EVOLVE);
    assign generation          = gen_q;
    assign seq_state           = state_q;
endmodule
